// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state encoding and timing constants for the Z80-style I/O bus.
package cpu_bus_pkg;
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, RECOVER} cpu_bus_state_t;
  localparam int TSTATES_PER_CYCLE = 5;
  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_MAX = 255;
endpackage

// File: rtl/cpu_io_initiator_tstate_timer.sv
// tstate_timer: loadable down-counter marking the final clk of each T-state.
module tstate_timer #(
  parameter int CLK_DIV = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [$clog2(CLK_DIV)-1:0] load_value,
  output logic                       last
);
  logic [$clog2(CLK_DIV)-1:0] r_cnt;
  // Holds at zero rather than wrapping; only a reload restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) r_cnt <= '0;
    else if (load) r_cnt <= load_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign last = r_cnt == '0;
endmodule

// File: rtl/cpu_io_initiator.sv
// cpu_io_initiator: drives Z80-style I/O read/write bus cycles from a request/response handshake.
// Define CPU_WAIT_EN to let wait_n stretch TW; otherwise wait_n is ignored.
module cpu_io_initiator
  import cpu_bus_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_port,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] A,
  output logic       rd_iorq_n,
  output logic       wr_iorq_n,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  input  logic [7:0] cd_in,
  input  logic       wait_n
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);
  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
    $error("CLK_DIV out of range");
  end
  cpu_bus_state_t r_state;
  logic r_write;
  logic w_last;
  logic w_accept;
  logic w_load;
  logic w_wait_done;
`ifdef CPU_WAIT_EN
  assign w_wait_done = wait_n;
`else
  logic w_unused;
  assign w_unused = wait_n;
  assign w_wait_done = 1'b1;
`endif
  assign w_accept = req_valid && req_ready;
  assign w_load = (r_state == IDLE) ? w_accept : w_last;
  tstate_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_value(LOAD),
    .last      (w_last)
  );
  // Every bus output is registered so each state's values appear the cycle it is entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      A         <= '0;
      rd_iorq_n <= 1'b1;
      wr_iorq_n <= 1'b1;
      cd_out    <= '0;
      cd_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state   <= T1;
          r_write   <= req_write;
          A         <= req_port;
          cd_out    <= req_write ? req_data : 8'h00;
          cd_oe     <= req_write;
          req_ready <= 1'b0;
        end
        T1: if (w_last) begin
          r_state   <= T2;
          rd_iorq_n <= r_write;
          wr_iorq_n <= !r_write;
        end
        T2: if (w_last) r_state <= TW;
        TW: if (w_last && w_wait_done) r_state <= T3;
        T3: if (w_last) begin
          r_state   <= RECOVER;
          rd_iorq_n <= 1'b1;
          wr_iorq_n <= 1'b1;
          rsp_data  <= r_write ? 8'h00 : cd_in;
        end
        RECOVER: if (w_last) begin
          r_state   <= IDLE;
          A         <= '0;
          cd_out    <= '0;
          cd_oe     <= 1'b0;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
